// File: rtl/operand_fetch_wb_pkg.sv
// Shared types and constants for the operand-fetch / writeback stage:
// register-file geometry, the captured-issue record and the bypass hit test.
package operand_fetch_wb_pkg;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  localparam reg_addr_t REG_R2 = 4'd2;
  localparam reg_addr_t REG_R3 = 4'd3;
  localparam reg_addr_t REG_R4 = 4'd4;
  localparam reg_addr_t REG_R6 = 4'd6;
  localparam reg_addr_t REG_R7 = 4'd7;

  typedef struct packed {
    reg_data_t op1;
    reg_data_t op2;
    reg_addr_t rd;
    logic      wr_rd;
  } issue_t;

  // True when this cycle's writeback targets addr.
  function automatic logic wb_hit(input logic wb_valid, input reg_addr_t wb_addr,
                                  input reg_addr_t addr);
    return wb_valid && (wb_addr == addr);
  endfunction

endpackage

// File: rtl/operand_fetch_wb_if.sv
// Decode, execute, writeback and register-file signals of the operand-fetch stage.
// The stage itself uses the slave modport; its environment uses master.
interface operand_fetch_wb_if;
  import operand_fetch_wb_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  logic      in_use_rs1;
  logic      in_use_rs2;
  reg_addr_t in_rd;
  logic      in_wr_rd;

  logic      out_valid;
  logic      out_ready;
  reg_data_t out_op1;
  reg_data_t out_op2;
  reg_addr_t out_rd;
  logic      out_wr_rd;

  logic      wb_valid;
  reg_addr_t wb_addr;
  reg_data_t wb_data;

  reg_addr_t rf_rport1_addr;
  reg_addr_t rf_rport2_addr;
  reg_data_t rf_rport1_data;
  reg_data_t rf_rport2_data;
  logic      rf_wport_enable;
  reg_addr_t rf_wport_addr;
  reg_data_t rf_wport_data;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_wr_rd,
    output in_ready,
    output out_valid, out_op1, out_op2, out_rd, out_wr_rd,
    input  out_ready,
    input  wb_valid, wb_addr, wb_data,
    output rf_rport1_addr, rf_rport2_addr,
    input  rf_rport1_data, rf_rport2_data,
    output rf_wport_enable, rf_wport_addr, rf_wport_data
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_wr_rd,
    input  in_ready,
    input  out_valid, out_op1, out_op2, out_rd, out_wr_rd,
    output out_ready,
    output wb_valid, wb_addr, wb_data,
    input  rf_rport1_addr, rf_rport2_addr,
    output rf_rport1_data, rf_rport2_data,
    input  rf_wport_enable, rf_wport_addr, rf_wport_data
  );

endinterface

// File: rtl/operand_fetch_wb_reg_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register marking an
// outstanding write. Clear from writeback, set from issue; set wins on a tie.
module operand_fetch_wb_reg_scoreboard
  import operand_fetch_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr_en_i,
  input  reg_addr_t clr_addr_i,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  reg_addr_t rs1_i,
  input  reg_addr_t rs2_i,
  input  reg_addr_t rd_i,
  output logic      busy_rs1_o,
  output logic      busy_rs2_o,
  output logic      busy_rd_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear first so a same-register set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en_i) begin
      busy_d[set_addr_i] = 1'b1;
    end else begin
      busy_d[set_addr_i] = busy_d[set_addr_i];
    end
  end

  // Busy vector state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups see the current state only; same-cycle clears are handled by the caller.
  assign busy_rs1_o = busy_q[rs1_i];
  assign busy_rs2_o = busy_q[rs2_i];
  assign busy_rd_o  = busy_q[rd_i];

endmodule

// File: rtl/operand_fetch_wb.sv
// Operand fetch with writeback bypass, RAW/WAW hazard stall and a single
// valid/ready output register feeding execute.
module operand_fetch_wb
  import operand_fetch_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  operand_fetch_wb_if.slave  bus
);

  logic      hit_rs1;
  logic      hit_rs2;
  logic      hit_rd;
  logic      busy_rs1;
  logic      busy_rs2;
  logic      busy_rd;
  logic      src_haz1;
  logic      src_haz2;
  logic      waw_haz;
  logic      in_ready;
  logic      accept;
  reg_data_t op1_byp;
  reg_data_t op2_byp;

  issue_t    out_q;
  issue_t    out_d;
  logic      out_valid_q;
  logic      out_valid_d;

  assign bus.rf_rport1_addr  = bus.in_rs1;
  assign bus.rf_rport2_addr  = bus.in_rs2;
  assign bus.rf_wport_enable = bus.wb_valid;
  assign bus.rf_wport_addr   = bus.wb_addr;
  assign bus.rf_wport_data   = bus.wb_data;

  // The file writes at the edge, so a same-cycle writeback must be forwarded
  // and also counts as already clearing the busy bit for hazard purposes.
  always_comb begin
    hit_rs1  = wb_hit(bus.wb_valid, bus.wb_addr, bus.in_rs1);
    hit_rs2  = wb_hit(bus.wb_valid, bus.wb_addr, bus.in_rs2);
    hit_rd   = wb_hit(bus.wb_valid, bus.wb_addr, bus.in_rd);
    op1_byp  = hit_rs1 ? bus.wb_data : bus.rf_rport1_data;
    op2_byp  = hit_rs2 ? bus.wb_data : bus.rf_rport2_data;
    src_haz1 = bus.in_use_rs1 && busy_rs1 && !hit_rs1;
    src_haz2 = bus.in_use_rs2 && busy_rs2 && !hit_rs2;
    waw_haz  = bus.in_wr_rd && busy_rd && !hit_rd;
    in_ready = (!out_valid_q || bus.out_ready) && !src_haz1 && !src_haz2 && !waw_haz;
    accept   = bus.in_valid && in_ready;
  end

  assign bus.in_ready = in_ready;

  // Output register next state: capture on accept, drain on ready, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_d.op1   = op1_byp;
      out_d.op2   = op2_byp;
      out_d.rd    = bus.in_rd;
      out_d.wr_rd = bus.in_wr_rd;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op1   = out_q.op1;
  assign bus.out_op2   = out_q.op2;
  assign bus.out_rd    = out_q.rd;
  assign bus.out_wr_rd = out_q.wr_rd;

  operand_fetch_wb_reg_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .clr_en_i   (bus.wb_valid),
    .clr_addr_i (bus.wb_addr),
    .set_en_i   (accept && bus.in_wr_rd),
    .set_addr_i (bus.in_rd),
    .rs1_i      (bus.in_rs1),
    .rs2_i      (bus.in_rs2),
    .rd_i       (bus.in_rd),
    .busy_rs1_o (busy_rs1),
    .busy_rs2_o (busy_rs2),
    .busy_rd_o  (busy_rd)
  );

endmodule

// File: tb/tb_operand_fetch_wb.sv
// Self-checking bench for operand_fetch_wb with a behavioural register file
// and an independent model of busy bits, output register and file contents.
module tb_operand_fetch_wb;
  import operand_fetch_wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_wb_if bus ();

  operand_fetch_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reg_data_t rf_mem [NREG];
  always @(posedge clk) begin
    if (bus.rf_wport_enable) rf_mem[bus.rf_wport_addr] <= bus.rf_wport_data;
  end
  assign bus.rf_rport1_data = rf_mem[bus.rf_rport1_addr];
  assign bus.rf_rport2_data = rf_mem[bus.rf_rport2_addr];

  int n_pass  = 0;
  int n_total = 0;

  logic [NREG-1:0] m_busy;
  logic            m_ov;
  reg_data_t       m_rf [NREG];
  issue_t          exp_q [$];
  issue_t          obs;

  function automatic logic m_hit(input reg_addr_t a);
    return bus.wb_valid && (bus.wb_addr == a);
  endfunction

  function automatic logic m_ready();
    logic h1, h2, hw;
    h1 = bus.in_use_rs1 && m_busy[bus.in_rs1] && !m_hit(bus.in_rs1);
    h2 = bus.in_use_rs2 && m_busy[bus.in_rs2] && !m_hit(bus.in_rs2);
    hw = bus.in_wr_rd && m_busy[bus.in_rd] && !m_hit(bus.in_rd);
    return (!m_ov || bus.out_ready) && !h1 && !h2 && !hw;
  endfunction

  function automatic issue_t m_issue();
    issue_t r;
    r.op1   = m_hit(bus.in_rs1) ? bus.wb_data : m_rf[bus.in_rs1];
    r.op2   = m_hit(bus.in_rs2) ? bus.wb_data : m_rf[bus.in_rs2];
    r.rd    = bus.in_rd;
    r.wr_rd = bus.in_wr_rd;
    return r;
  endfunction

  task automatic drive_instr(input logic v, input reg_addr_t rs1, input logic u1,
                             input reg_addr_t rs2, input logic u2,
                             input reg_addr_t rd, input logic wr);
    bus.in_valid = v; bus.in_rs1 = rs1; bus.in_use_rs1 = u1;
    bus.in_rs2 = rs2; bus.in_use_rs2 = u2; bus.in_rd = rd; bus.in_wr_rd = wr;
  endtask

  task automatic drive_wb(input logic v, input reg_addr_t a, input reg_data_t d);
    bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
  endtask

  // Update the model with what happens at the coming edge, then step past it.
  task automatic advance();
    logic acc, fire;
    acc  = bus.in_valid && m_ready();
    fire = m_ov && bus.out_ready;
    if (fire && exp_q.size() > 0) exp_q.delete(0);
    if (acc) exp_q.push_back(m_issue());
    m_ov = acc || (m_ov && !bus.out_ready);
    if (bus.wb_valid) begin
      m_busy[bus.wb_addr] = 1'b0;
      m_rf[bus.wb_addr]   = bus.wb_data;
    end
    if (acc && bus.in_wr_rd) m_busy[bus.in_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive_instr(1'b1, REG_R2, 1'b1, REG_R3, 1'b1, REG_R4, 1'b1);
    drive_wb(1'b0, 4'd0, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_op1 !== 32'd0) $display("FAIL reset_op1 got %h want 0", bus.out_op1); else n_pass++;
    n_total++; if (bus.out_op2 !== 32'd0) $display("FAIL reset_op2 got %h want 0", bus.out_op2); else n_pass++;
    n_total++; if ({bus.out_rd, bus.out_wr_rd} !== 5'd0) $display("FAIL reset_rd got %h/%b want 0/0", bus.out_rd, bus.out_wr_rd); else n_pass++;
    n_total++; if (dut.u_sb.busy_q !== 16'h0000) $display("FAIL reset_busy got %h want 0000", dut.u_sb.busy_q); else n_pass++;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    m_busy = 16'h0000; m_ov = 1'b0; exp_q.delete();
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_operands();
    reg_data_t d;
    drive_wb(1'b1, REG_R2, 32'h0000_0005); advance();
    drive_wb(1'b1, REG_R3, 32'h0000_0007); advance();
    drive_wb(1'b0, 4'd0, 32'd0);
    drive_instr(1'b1, REG_R2, 1'b1, REG_R3, 1'b1, REG_R4, 1'b1);
    #1;
    n_total++; if (bus.in_ready !== m_ready()) $display("FAIL issue_ready got %b want %b", bus.in_ready, m_ready()); else n_pass++;
    advance();
    bus.in_valid = 1'b0;
    obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
    n_total++; if (bus.out_valid !== m_ov) $display("FAIL issue_valid got %b want %b", bus.out_valid, m_ov); else n_pass++;
    n_total++; if (obs !== exp_q[0]) $display("FAIL issue_data got %h want %h", obs, exp_q[0]); else n_pass++;
    n_total++; if ({bus.out_op1, bus.out_op2, bus.out_rd} !== {32'h5, 32'h7, 4'd4}) $display("FAIL issue_const got %h/%h/%h want 5/7/4", bus.out_op1, bus.out_op2, bus.out_rd); else n_pass++;
    n_total++; if (dut.u_sb.busy_q !== m_busy) $display("FAIL issue_busy got %h want %h", dut.u_sb.busy_q, m_busy); else n_pass++;
    // Writeback to non-busy registers read in the same cycle: bypass patterns.
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive_wb(1'b1, reg_addr_t'(8 + i), d);
      drive_instr(1'b1, reg_addr_t'(8 + i), 1'b1, REG_R2, 1'b1, 4'd0, 1'b0);
      #1;
      n_total++; if (bus.in_ready !== m_ready()) $display("FAIL byp_ready[%0d] got %b want %b", i, bus.in_ready, m_ready()); else n_pass++;
      advance();
      obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
      n_total++; if (bus.out_valid !== m_ov || obs !== exp_q[0]) $display("FAIL byp_data[%0d] got %b/%h want %b/%h", i, bus.out_valid, obs, m_ov, exp_q[0]); else n_pass++;
      n_total++; if (dut.u_sb.busy_q !== m_busy) $display("FAIL byp_busy[%0d] got %h want %h", i, dut.u_sb.busy_q, m_busy); else n_pass++;
    end
    drive_wb(1'b0, 4'd0, 32'd0);
    bus.in_valid = 1'b0;
    advance();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_raw();
    drive_instr(1'b1, REG_R4, 1'b1, REG_R3, 1'b1, 4'd5, 1'b0);
    #1;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL raw_stall got %b want 0", bus.in_ready); else n_pass++;
    advance();
    n_total++; if (bus.out_valid !== m_ov) $display("FAIL raw_no_issue got %b want %b", bus.out_valid, m_ov); else n_pass++;
    drive_wb(1'b1, REG_R4, 32'hF00A_F00A);
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_release got %b want 1", bus.in_ready); else n_pass++;
    advance();
    drive_wb(1'b0, 4'd0, 32'd0);
    bus.in_valid = 1'b0;
    obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
    n_total++; if (bus.out_valid !== m_ov || obs !== exp_q[0]) $display("FAIL raw_data got %b/%h want %b/%h", bus.out_valid, obs, m_ov, exp_q[0]); else n_pass++;
    n_total++; if (bus.out_op1 !== 32'hF00A_F00A) $display("FAIL raw_bypass got %h want f00af00a", bus.out_op1); else n_pass++;
    n_total++; if (dut.u_sb.busy_q[4] !== 1'b0) $display("FAIL raw_busy4 got %b want 0", dut.u_sb.busy_q[4]); else n_pass++;
  endtask

  task automatic test_waw();
    drive_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, REG_R4, 1'b1);
    advance();
    n_total++; if (dut.u_sb.busy_q[4] !== 1'b1) $display("FAIL waw_first_busy got %b want 1", dut.u_sb.busy_q[4]); else n_pass++;
    #1;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL waw_stall got %b want 0", bus.in_ready); else n_pass++;
    advance();
    drive_wb(1'b1, REG_R4, 32'h1234_5678);
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL waw_release got %b want 1", bus.in_ready); else n_pass++;
    advance();
    drive_wb(1'b0, 4'd0, 32'd0);
    bus.in_valid = 1'b0;
    n_total++; if (dut.u_sb.busy_q !== m_busy || m_busy[4] !== 1'b1) $display("FAIL waw_set_wins got %h want %h", dut.u_sb.busy_q, m_busy); else n_pass++;
    obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
    n_total++; if (bus.out_valid !== m_ov || obs !== exp_q[0]) $display("FAIL waw_data got %b/%h want %b/%h", bus.out_valid, obs, m_ov, exp_q[0]); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_instr(1'b1, REG_R2, 1'b1, REG_R3, 1'b1, REG_R7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, bus.in_ready); else n_pass++;
      advance();
      obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
      n_total++; if (bus.out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, bus.out_valid, obs, exp_q[0]); else n_pass++;
    end
    bus.out_ready = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", bus.in_ready); else n_pass++;
    advance();
    bus.in_valid = 1'b0;
    obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
    n_total++; if (bus.out_valid !== m_ov || obs !== exp_q[0]) $display("FAIL bp_next got %b/%h want %b/%h", bus.out_valid, obs, m_ov, exp_q[0]); else n_pass++;
    n_total++; if ({bus.out_op1, bus.out_rd} !== {32'h5, 4'd7}) $display("FAIL bp_next_const got %h/%h want 5/7", bus.out_op1, bus.out_rd); else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    drive_wb(1'b1, REG_R6, 32'hA5A5_0006); advance();
    drive_wb(1'b0, 4'd0, 32'd0);
    drive_instr(1'b1, REG_R6, 1'b1, REG_R6, 1'b1, REG_R6, 1'b1);
    #1;
    n_total++; if (bus.in_ready !== m_ready()) $display("FAIL same_ready got %b want %b", bus.in_ready, m_ready()); else n_pass++;
    advance();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    obs = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wr_rd};
    n_total++; if (bus.out_valid !== m_ov || obs !== exp_q[0]) $display("FAIL same_data got %b/%h want %b/%h", bus.out_valid, obs, m_ov, exp_q[0]); else n_pass++;
    n_total++; if (dut.u_sb.busy_q[6] !== 1'b1) $display("FAIL same_busy6 got %b want 1", dut.u_sb.busy_q[6]); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (dut.u_sb.busy_q !== 16'h0000) $display("FAIL midrst_busy got %h want 0000", dut.u_sb.busy_q); else n_pass++;
    m_busy = 16'h0000; m_ov = 1'b0; exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    drive_instr(1'b1, REG_R6, 1'b1, REG_R4, 1'b1, REG_R6, 1'b1);
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", bus.in_ready); else n_pass++;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rf_mem[i] = 32'd0;
      m_rf[i]   = 32'd0;
    end
    m_busy = 16'h0000;
    m_ov   = 1'b0;
    test_reset();
    test_operands();
    test_raw();
    test_waw();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
